// File: rtl/m2_block_scheduler_if.sv
// Handshake bundle between the milestone-2 scheduler and its block units.
// master = scheduler side, slave = block-unit / top-level side.
interface m2_block_scheduler_if;
  logic        M2_start;
  logic        M2_done;
  logic        M2_busy;
  logic        FS_start;
  logic        CT_start;
  logic        CS_start;
  logic        WS_start;
  logic        FS_done;
  logic        CT_done;
  logic        CS_done;
  logic        WS_done;
  logic [17:0] FS_base_address;
  logic [17:0] WS_base_address;

  modport master (
    input  M2_start,
    input  FS_done,
    input  CT_done,
    input  CS_done,
    input  WS_done,
    output M2_done,
    output M2_busy,
    output FS_start,
    output CT_start,
    output CS_start,
    output WS_start,
    output FS_base_address,
    output WS_base_address
  );

  modport slave (
    output M2_start,
    output FS_done,
    output CT_done,
    output CS_done,
    output WS_done,
    input  M2_done,
    input  M2_busy,
    input  FS_start,
    input  CT_start,
    input  CS_start,
    input  WS_start,
    input  FS_base_address,
    input  WS_base_address
  );
endinterface

// File: rtl/m2_block_scheduler.sv
// IDCT milestone-2 sequencer: walks Y/U/V 8x8 blocks and
// overlaps FS(n+1) with CS(n) and WS(n) with CT(n+1).
module m2_block_scheduler #(
  parameter int Y_COL_BLOCKS = 40,
  parameter int ROW_BLOCKS   = 30,
  parameter int PRE_Y_BASE   = 76800,
  parameter int PRE_U_BASE   = 153600,
  parameter int PRE_V_BASE   = 192000,
  parameter int POST_Y_BASE  = 0,
  parameter int POST_U_BASE  = 38400,
  parameter int POST_V_BASE  = 57600
) (
  input logic                  CLOCK_50_I,
  input logic                  Reset,
  m2_block_scheduler_if.master sched
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_FS,
    S_LEAD_CT,
    S_PAIR_A,
    S_PAIR_B,
    S_LEAD_CS,
    S_LEAD_WS
  } state_t;

  typedef struct packed {
    logic [1:0] seg;
    logic [4:0] row;
    logic [5:0] col;
  } blk_t;

  localparam logic [5:0] Y_C_END  = 6'(Y_COL_BLOCKS - 1);
  localparam logic [5:0] UV_C_END = 6'(Y_COL_BLOCKS / 2 - 1);
  localparam logic [4:0] R_END    = 5'(ROW_BLOCKS - 1);

  localparam logic [17:0] PRE_Y  = 18'(PRE_Y_BASE);
  localparam logic [17:0] PRE_U  = 18'(PRE_U_BASE);
  localparam logic [17:0] PRE_V  = 18'(PRE_V_BASE);
  localparam logic [17:0] POST_Y = 18'(POST_Y_BASE);
  localparam logic [17:0] POST_U = 18'(POST_U_BASE);
  localparam logic [17:0] POST_V = 18'(POST_V_BASE);

  // One block row is 8 pixel rows of PW pixels (pre) or PW/2 words (post).
  localparam logic [17:0] FS_ROW_Y  = 18'(64 * Y_COL_BLOCKS);
  localparam logic [17:0] FS_ROW_UV = 18'(32 * Y_COL_BLOCKS);
  localparam logic [17:0] WS_ROW_Y  = 18'(32 * Y_COL_BLOCKS);
  localparam logic [17:0] WS_ROW_UV = 18'(16 * Y_COL_BLOCKS);

  function automatic blk_t blk_next(input blk_t b);
    blk_t       n;
    logic [5:0] c_end;
    n     = b;
    c_end = (b.seg == 2'd0) ? Y_C_END : UV_C_END;
    if (b.col == c_end) begin
      n.col = '0;
      if (b.row == R_END) begin
        n.row = '0;
        n.seg = b.seg + 2'd1;
      end else begin
        n.row = b.row + 5'd1;
      end
    end else begin
      n.col = b.col + 6'd1;
    end
    return n;
  endfunction

  state_t state;
  state_t state_n;
  logic   first;
  logic   done_q;

  logic run_fs, run_ct, run_cs, run_ws;
  logic fs_got, ct_got, cs_got, ws_got;
  logic acc_fs, acc_ct, acc_cs, acc_ws;
  logic exit_ok;

  blk_t f_blk;
  blk_t w_blk;
  logic fetch_exh;
  logic f_last;
  logic w_last;

  always_comb begin
    run_fs = 1'b0;
    run_ct = 1'b0;
    run_cs = 1'b0;
    run_ws = 1'b0;
    unique case (state)
      S_LEAD_FS: run_fs = 1'b1;
      S_LEAD_CT: run_ct = 1'b1;
      S_PAIR_A: begin
        run_cs = 1'b1;
        run_fs = 1'b1;
      end
      S_PAIR_B: begin
        run_ct = 1'b1;
        run_ws = 1'b1;
      end
      S_LEAD_CS: run_cs = 1'b1;
      S_LEAD_WS: run_ws = 1'b1;
      default: ;
    endcase
  end

  // Dones in the start cycle or for idle units are dropped.
  assign acc_fs = run_fs & sched.FS_done & ~first & ~fs_got;
  assign acc_ct = run_ct & sched.CT_done & ~first & ~ct_got;
  assign acc_cs = run_cs & sched.CS_done & ~first & ~cs_got;
  assign acc_ws = run_ws & sched.WS_done & ~first & ~ws_got;

  assign exit_ok = (state != S_IDLE) & ~first
                 & (~run_fs | fs_got | acc_fs)
                 & (~run_ct | ct_got | acc_ct)
                 & (~run_cs | cs_got | acc_cs)
                 & (~run_ws | ws_got | acc_ws);

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      first  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      first  <= (state_n != state) && (state_n != S_IDLE);
      done_q <= (state == S_LEAD_WS) && exit_ok;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (sched.M2_start) state_n = S_LEAD_FS;
      S_LEAD_FS: if (exit_ok) state_n = S_LEAD_CT;
      S_LEAD_CT: if (exit_ok) state_n = S_PAIR_A;
      S_PAIR_A:  if (exit_ok) state_n = S_PAIR_B;
      S_PAIR_B:  if (exit_ok) state_n = fetch_exh ? S_LEAD_CS : S_PAIR_A;
      S_LEAD_CS: if (exit_ok) state_n = S_LEAD_WS;
      S_LEAD_WS: if (exit_ok) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    sched.FS_start = first & run_fs;
    sched.CT_start = first & run_ct;
    sched.CS_start = first & run_cs;
    sched.WS_start = first & run_ws;
    sched.M2_busy  = (state != S_IDLE);
    sched.M2_done  = done_q;
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      fs_got <= 1'b0;
      ct_got <= 1'b0;
      cs_got <= 1'b0;
      ws_got <= 1'b0;
    end else if (exit_ok) begin
      fs_got <= 1'b0;
      ct_got <= 1'b0;
      cs_got <= 1'b0;
      ws_got <= 1'b0;
    end else begin
      fs_got <= fs_got | acc_fs;
      ct_got <= ct_got | acc_ct;
      cs_got <= cs_got | acc_cs;
      ws_got <= ws_got | acc_ws;
    end
  end

  assign f_last = (f_blk.seg == 2'd2) && (f_blk.row == R_END)
               && (f_blk.col == UV_C_END);
  assign w_last = (w_blk.seg == 2'd2) && (w_blk.row == R_END)
               && (w_blk.col == UV_C_END);

  // Both counters park on the final V block so addresses stay valid.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      f_blk     <= '0;
      w_blk     <= '0;
      fetch_exh <= 1'b0;
    end else if ((state == S_IDLE) && sched.M2_start) begin
      f_blk     <= '0;
      w_blk     <= '0;
      fetch_exh <= 1'b0;
    end else begin
      if (acc_fs && !fetch_exh) begin
        if (f_last) fetch_exh <= 1'b1;
        else        f_blk     <= blk_next(f_blk);
      end
      if (acc_ws && !w_last) w_blk <= blk_next(w_blk);
    end
  end

  logic [17:0] fs_base;
  logic [17:0] fs_step;
  logic [17:0] ws_base;
  logic [17:0] ws_step;

  always_comb begin
    fs_base = PRE_Y;
    fs_step = FS_ROW_Y;
    unique case (f_blk.seg)
      2'd1: begin
        fs_base = PRE_U;
        fs_step = FS_ROW_UV;
      end
      2'd2: begin
        fs_base = PRE_V;
        fs_step = FS_ROW_UV;
      end
      default: ;
    endcase
    ws_base = POST_Y;
    ws_step = WS_ROW_Y;
    unique case (w_blk.seg)
      2'd1: begin
        ws_base = POST_U;
        ws_step = WS_ROW_UV;
      end
      2'd2: begin
        ws_base = POST_V;
        ws_step = WS_ROW_UV;
      end
      default: ;
    endcase
    sched.FS_base_address = fs_base + 18'(f_blk.row) * fs_step
                          + 18'({f_blk.col, 3'b000});
    sched.WS_base_address = ws_base + 18'(w_blk.row) * ws_step
                          + 18'({w_blk.col, 2'b00});
  end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: three configurations run against a
// step-list model of the FS/CT/CS/WS schedule and block addresses.
module tb_m2_block_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [2:0] m2s;
  logic [2:0] dfs, dct, dcs, dws;

  m2_block_scheduler_if b0 ();
  m2_block_scheduler_if b1 ();
  m2_block_scheduler_if b2 ();

  assign b0.M2_start = m2s[0];
  assign b0.FS_done  = dfs[0];
  assign b0.CT_done  = dct[0];
  assign b0.CS_done  = dcs[0];
  assign b0.WS_done  = dws[0];
  assign b1.M2_start = m2s[1];
  assign b1.FS_done  = dfs[1];
  assign b1.CT_done  = dct[1];
  assign b1.CS_done  = dcs[1];
  assign b1.WS_done  = dws[1];
  assign b2.M2_start = m2s[2];
  assign b2.FS_done  = dfs[2];
  assign b2.CT_done  = dct[2];
  assign b2.CS_done  = dcs[2];
  assign b2.WS_done  = dws[2];

  m2_block_scheduler #(.Y_COL_BLOCKS(2), .ROW_BLOCKS(1)) u0 (
    .CLOCK_50_I(clk), .Reset(rst[0]), .sched(b0));
  m2_block_scheduler #(.Y_COL_BLOCKS(2), .ROW_BLOCKS(2)) u1 (
    .CLOCK_50_I(clk), .Reset(rst[1]), .sched(b1));
  m2_block_scheduler u2 (
    .CLOCK_50_I(clk), .Reset(rst[2]), .sched(b2));

  logic [3:0]  st [3];
  logic [2:0]  busy, mdone;
  logic [17:0] fsa [3];
  logic [17:0] wsa [3];

  assign st[0] = {b0.WS_start, b0.CS_start, b0.CT_start, b0.FS_start};
  assign st[1] = {b1.WS_start, b1.CS_start, b1.CT_start, b1.FS_start};
  assign st[2] = {b2.WS_start, b2.CS_start, b2.CT_start, b2.FS_start};
  assign busy  = {b2.M2_busy, b1.M2_busy, b0.M2_busy};
  assign mdone = {b2.M2_done, b1.M2_done, b0.M2_done};
  assign fsa[0] = b0.FS_base_address;
  assign fsa[1] = b1.FS_base_address;
  assign fsa[2] = b2.FS_base_address;
  assign wsa[0] = b0.WS_base_address;
  assign wsa[1] = b1.WS_base_address;
  assign wsa[2] = b2.WS_base_address;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int i, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] cycle %0d: got %0d expected %0d",
               nm, i, cyc, act, exp);
    end
  endtask

  function automatic int yc(input int i);
    return (i == 2) ? 40 : 2;
  endfunction
  function automatic int rb(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 30);
  endfunction
  function automatic int nblk(input int i);
    return 2 * rb(i) * yc(i);
  endfunction

  // Step k of the schedule: bit0 FS, bit1 CT, bit2 CS, bit3 WS.
  function automatic logic [3:0] units(input int i, input int k);
    int n;
    n = nblk(i);
    if (k == 0)     return 4'b0001;
    if (k == 1)     return 4'b0010;
    if (k == 2*n)   return 4'b0100;
    if (k == 2*n+1) return 4'b1000;
    return (k % 2 == 0) ? 4'b0101 : 4'b1010;
  endfunction
  function automatic int fs_blk(input int k);
    return (k == 0) ? 0 : (k - 2) / 2 + 1;
  endfunction
  function automatic int ws_blk(input int i, input int k);
    return (k == 2*nblk(i)+1) ? nblk(i) - 1 : (k - 2) / 2;
  endfunction

  // Linear block index -> plane, row, column -> SRAM address.
  function automatic int blk_addr(input int i, input int b, input bit post);
    int w, base, r, c, ny, nu, bb;
    bb   = b;
    ny   = rb(i) * yc(i);
    w    = yc(i);
    base = post ? 0 : 76800;
    if (bb >= ny) begin
      bb -= ny;
      w  = yc(i) / 2;
      nu = rb(i) * w;
      if (bb >= nu) begin
        bb  -= nu;
        base = post ? 57600 : 192000;
      end else begin
        base = post ? 38400 : 153600;
      end
    end
    r = bb / w;
    c = bb % w;
    if (post) return base + r * 8 * (4 * w) + c * 4;
    return base + r * 8 * (8 * w) + c * 8;
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 20));
    return int'($urandom_range(1, 3));
  endfunction

  int         k      [3];
  logic [3:0] pend   [3];
  bit         fresh  [3];
  bit         dexp   [3];
  int         cnt    [3][4];
  int         scnt   [3];
  int         st_cnt [3][4];
  int         done_cnt [3] = '{0, 0, 0};
  int         pa     [3];
  int         pb     [3];
  int         fs_n   [3];
  int         ws_n   [3];
  int         fs_rec [2][16];
  int         ws_rec [2][16];
  int         lat    [3][4];
  bit [2:0]   rnd;
  bit [2:0]   stray;
  logic [3:0] exp_st;
  logic [3:0] dv;

  // Compare, respond with dones, then advance the model by one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        chk("rst_starts", i, int'(st[i]), 0);
        chk("rst_busy", i, int'(busy[i]), 0);
        chk("rst_m2_done", i, int'(mdone[i]), 0);
        chk("rst_fs_addr", i, int'(fsa[i]), 76800);
        chk("rst_ws_addr", i, int'(wsa[i]), 0);
        k[i] = -1; pend[i] = '0; fresh[i] = 0; dexp[i] = 0;
        scnt[i] = 0; pa[i] = -1; pb[i] = -1; fs_n[i] = 0; ws_n[i] = 0;
        for (int u = 0; u < 4; u++) cnt[i][u] = 0;
        dfs[i] = 0; dct[i] = 0; dcs[i] = 0; dws[i] = 0;
      end else begin
        exp_st = fresh[i] ? units(i, k[i]) : 4'b0000;
        chk("starts", i, int'(st[i]), int'(exp_st));
        chk("busy", i, int'(busy[i]), (k[i] >= 0) ? 1 : 0);
        chk("m2_done", i, int'(mdone[i]), int'(dexp[i]));
        if (fresh[i] && exp_st[0]) begin
          chk("fs_addr", i, int'(fsa[i]), blk_addr(i, fs_blk(k[i]), 0));
          if (i < 2 && fs_n[i] < 16) fs_rec[i][fs_n[i]] = int'(fsa[i]);
          fs_n[i]++;
        end
        if (fresh[i] && exp_st[3]) begin
          chk("ws_addr", i, int'(wsa[i]), blk_addr(i, ws_blk(i, k[i]), 1));
          if (i < 2 && ws_n[i] < 16) ws_rec[i][ws_n[i]] = int'(wsa[i]);
          ws_n[i]++;
        end
        for (int u = 0; u < 4; u++) st_cnt[i][u] += int'(st[i][u]);
        if (mdone[i]) done_cnt[i]++;
        if (st[i] == 4'b0101 && pa[i] < 0) pa[i] = cyc;
        if (st[i] == 4'b1010 && pa[i] >= 0 && pb[i] < 0) pb[i] = cyc;

        dv = '0;
        for (int u = 0; u < 4; u++) begin
          if (cnt[i][u] > 0) begin
            cnt[i][u]--;
            if (cnt[i][u] == 0) dv[u] = 1'b1;
          end
        end
        if (scnt[i] > 0) begin
          scnt[i]--;
          if (scnt[i] == 0) dv[1] = 1'b1;
        end
        for (int u = 0; u < 4; u++)
          if (st[i][u]) cnt[i][u] = rnd[i] ? rand_lat() : lat[i][u];
        if (stray[i] && st[i][2]) scnt[i] = 2;
        dfs[i] = dv[0]; dct[i] = dv[1]; dcs[i] = dv[2]; dws[i] = dv[3];

        dexp[i] = 0;
        if (k[i] < 0) begin
          if (m2s[i]) begin
            k[i] = 0; pend[i] = units(i, 0); fresh[i] = 1;
            pa[i] = -1; pb[i] = -1; fs_n[i] = 0; ws_n[i] = 0;
            for (int u = 0; u < 4; u++) st_cnt[i][u] = 0;
          end
        end else if (fresh[i]) begin
          fresh[i] = 0;
        end else begin
          pend[i] = pend[i] & ~dv;
          if (pend[i] == 4'b0000) begin
            k[i]++;
            if (k[i] == 2 * nblk(i) + 2) begin
              k[i] = -1; dexp[i] = 1;
            end else begin
              pend[i] = units(i, k[i]); fresh[i] = 1;
            end
          end
        end
      end
    end
  end

  task automatic wait_done(input int i, input int prev, input int budget);
    int t;
    t = 0;
    while (done_cnt[i] == prev && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk("run_complete", i, (done_cnt[i] != prev) ? 1 : 0, 1);
  endtask

  task automatic check_counts(input int i);
    for (int u = 0; u < 4; u++) chk("start_count", i, st_cnt[i][u], nblk(i));
  endtask

  int fsq [4] = '{76800, 76808, 153600, 192000};
  int wsq [4] = '{0, 4, 38400, 57600};

  initial begin
    int t;
    rst   = 3'b111;
    m2s   = 3'b000;
    rnd   = 3'b100;
    stray = 3'b010;
    for (int i = 0; i < 3; i++)
      for (int u = 0; u < 4; u++) lat[i][u] = 5;
    lat[1][0] = 3;
    lat[1][2] = 40;
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    @(posedge clk); #1 m2s = 3'b111;
    @(posedge clk); #1 m2s = 3'b000;
    repeat (8) @(posedge clk);
    #1 m2s[0] = 1'b1;
    @(posedge clk); #1 m2s[0] = 1'b0;

    wait_done(0, 0, 1000);
    chk("m2_done_count", 0, done_cnt[0], 1);
    check_counts(0);
    for (int j = 0; j < 4; j++) begin
      chk("fs_seq", 0, fs_rec[0][j], fsq[j]);
      chk("ws_seq", 0, ws_rec[0][j], wsq[j]);
    end

    wait_done(1, 0, 3000);
    chk("m2_done_count", 1, done_cnt[1], 1);
    check_counts(1);
    chk("y10_fs", 1, fs_rec[1][2], 76928);
    chk("y10_ws", 1, ws_rec[1][2], 64);
    chk("u10_fs", 1, fs_rec[1][5], 153664);
    chk("u10_ws", 1, ws_rec[1][5], 38432);
    chk("skew_gap", 1, pb[1] - pa[1], 41);

    for (int u = 0; u < 4; u++) lat[1][u] = 5;
    @(posedge clk); #1 m2s[1] = 1'b1;
    @(posedge clk); #1 m2s[1] = 1'b0;
    t = 0;
    while (pb[1] < 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("pair_b_reached", 1, (pb[1] >= 0) ? 1 : 0, 1);
    chk("same_cycle_gap", 1, pb[1] - pa[1], 6);
    #1 rst[1] = 1'b1;
    #1;
    chk("rst_imm_busy", 1, int'(busy[1]), 0);
    chk("rst_imm_fs_addr", 1, int'(fsa[1]), 76800);
    repeat (2) @(posedge clk);
    #1 rst[1] = 1'b0;
    chk("no_done_on_reset", 1, done_cnt[1], 1);
    @(posedge clk); #1 m2s[1] = 1'b1;
    @(posedge clk); #1 m2s[1] = 1'b0;
    wait_done(1, 1, 3000);
    check_counts(1);
    chk("restart_fs0", 1, fs_rec[1][0], 76800);
    chk("m2_done_count", 1, done_cnt[1], 2);

    wait_done(2, 0, 80000);
    check_counts(2);
    chk("final_fs", 2, int'(fsa[2]), 229272);
    chk("final_ws", 2, int'(wsa[2]), 76236);
    repeat (5) @(posedge clk);
    chk("m2_done_count", 2, done_cnt[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
